// File: rtl/mcs51_uart_boot_loader_if.sv
// Code memory write port driven by the UART boot loader.
interface mcs51_uart_boot_loader_if;
  logic        code_we;
  logic [15:0] code_waddr;
  logic [7:0]  code_wdata;

  modport master (
    output code_we,
    output code_waddr,
    output code_wdata
  );

  modport slave (
    input code_we,
    input code_waddr,
    input code_wdata
  );
endinterface

// File: rtl/mcs51_uart_boot_loader.sv
// Holds the MCS-51 core in reset while an image arrives over 8N1 UART, writes it into
// code memory, verifies the additive checksum and then releases the core.
module mcs51_uart_boot_loader #(
  parameter int unsigned CODE_SIZE    = 4096,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'h55
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            boot_en,
  input  logic                            rxd,
  mcs51_uart_boot_loader_if.master        code_wr,
  output logic                            core_reset_n,
  output logic                            boot_done,
  output logic                            boot_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]     CodeSizeW = 17'(CODE_SIZE);

  typedef enum logic [2:0] {RxWaitHigh, RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {
    StInit, StWaitSync, StLenHi, StLenLo, StData, StChk, StDone, StError
  } st_e;

  // rxd synchronizer
  logic rxd_meta_q, rxd_s_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // Starting in RxWaitHigh keeps a character interrupted by reset from being decoded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= RxWaitHigh;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RxWaitHigh: if (rxd_s_q) rx_state_d = RxIdle;
      RxIdle: begin
        if (!rxd_s_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d = '0;
          if (rxd_s_q) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RxIdle;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RxWaitHigh;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxWaitHigh;
    endcase
  end

  st_e         st_q, st_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0]  sum_next;
  logic [15:0] len_full;
  assign sum_next = sum_q + rx_shift_q;
  assign len_full = {len_hi_q, rx_shift_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= StInit;
      len_hi_q     <= '0;
      remaining_q  <= '0;
      sum_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      len_hi_q     <= len_hi_d;
      remaining_q  <= remaining_d;
      sum_q        <= sum_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    len_hi_d     = len_hi_q;
    remaining_d  = remaining_q;
    sum_d        = sum_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q | (st_q == StDone);
    done_d       = done_q | (st_q == StDone);
    // Address advances the cycle after each strobe, so it equals the length at frame end.
    waddr_d      = we_q ? waddr_q + 16'd1 : waddr_q;
    unique case (st_q)
      StInit: st_d = boot_en ? StWaitSync : StDone;
      StWaitSync: begin
        if (byte_valid_q && rx_shift_q == SYNC_BYTE) begin
          st_d    = StLenHi;
          err_d   = 1'b0;
          sum_d   = '0;
          waddr_d = '0;
        end
      end
      StLenHi: begin
        if (byte_valid_q) begin
          len_hi_d = rx_shift_q;
          sum_d    = sum_next;
          st_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (byte_valid_q) begin
          sum_d       = sum_next;
          remaining_d = len_full;
          if ({1'b0, len_full} > CodeSizeW) st_d = StError;
          else if (len_full == 16'd0)       st_d = StChk;
          else                              st_d = StData;
        end
      end
      StData: begin
        if (byte_valid_q) begin
          we_d        = 1'b1;
          wdata_d     = rx_shift_q;
          sum_d       = sum_next;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) st_d = StChk;
        end
      end
      StChk: begin
        if (byte_valid_q) st_d = (sum_next == 8'h00) ? StDone : StError;
      end
      StDone: st_d = StDone;
      StError: begin
        err_d = 1'b1;
        st_d  = StWaitSync;
      end
      default: st_d = StInit;
    endcase
    if (frame_err_q && st_q != StInit && st_q != StDone && st_q != StError) begin
      st_d = StError;
      we_d = 1'b0;
    end
  end

  assign code_wr.code_we    = we_q;
  assign code_wr.code_waddr = waddr_q;
  assign code_wr.code_wdata = wdata_q;
  assign core_reset_n       = core_rst_n_q;
  assign boot_done          = done_q;
  assign boot_error         = err_q;

endmodule
